decoder_3to8_pulse: RTL and testbench
=====================================

// Module: decoder_3to8_pulse
// PURPOSE
//  Sequenced 3-to-8 decoder, the inverse of our 8-to-3 priority encoder.
//  Accepts a 3-bit index over a valid/ready handshake and drives the decoded
//  one-hot word on y for PULSE_LEN cycles, then holds y low for GAP_LEN cycles.
//  Used to replay encoded select/grant indices as timed strobe lines.
// PARAMETERS
//  PULSE_LEN  4  cycles y is held active per accepted index; legal 1..255
//  GAP_LEN    1  cycles y is forced to 0 after each pulse; legal 0..255
//  CW         8  width of the internal down-counter; must hold max(PULSE_LEN,GAP_LEN)-1
// PORTS
//  clk       in   1  single clock, rising edge
//  rst_n     in   1  asynchronous, active-low reset
//  in_valid  in   1  in_idx is valid this cycle
//  in_idx    in   3  encoded index 0..7 (000 -> y[0], 111 -> y[7])
//  in_ready  out  1  block can accept an index; high only in IDLE
//  y         out  8  decoded output word, registered
//  busy      out  1  high in DRIVE or GAP
//  done      out  1  one-cycle pulse on the last DRIVE cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, y=8'h00, done=0, busy=0,
//    counter=0, idx register=0. in_ready = (state==IDLE), so in_ready=1 during reset.
//  - FSM states: IDLE, DRIVE, GAP.
//  - IDLE: y=0. On in_valid&&in_ready, latch in_idx, load counter=PULSE_LEN-1,
//    and go to DRIVE. y becomes active on the next cycle, so latency is 1 cycle.
//  - DRIVE: y=decode(idx), held stable.
//    - counter!=0: decrement.
//    - counter==0: done=1 this cycle. If GAP_LEN==0, go to IDLE; otherwise
//      load counter=GAP_LEN-1 and go to GAP.
//  - GAP: y=0. Decrement the counter; when counter==0, go to IDLE.
//  - Timing: y is active for exactly PULSE_LEN cycles. y is 0 for exactly
//    GAP_LEN cycles, then for 1 IDLE cycle.
//    - Minimum period between accepts is PULSE_LEN+GAP_LEN+1 cycles.
//  - in_valid while not ready: ignored and not queued. The source must hold it
//    until ready.
//  - in_idx changes during DRIVE: no effect, because y decodes the latched idx.
//  - y and done are registered outputs. in_ready and busy decode directly from
//    the state register, with no combinational path from the inputs.
//  - Reset mid-DRIVE/GAP: y drops to 0 immediately. The pending pulse is lost,
//    with no done pulse.
//  - X/Z on in_idx at accept: y=8'hxx in simulation. The bench must flag this
//    with an assertion; no recovery logic.
// CONFIGURATION
//  - DEC_THERMO_EN defined: y is a thermometer code, y[i]=1 for all i<=idx
//    (idx=3 -> 8'b0000_1111). This matches the input pattern the priority
//    encoder resolves.
//  - DEC_THERMO_EN undefined (default): y is one-hot (idx=3 -> 8'b0000_1000).
//  - Timing, handshake and all other outputs are identical in both builds.
// STRUCTURE
//  - Package decoder_pkg:
//    - state encoding constants S_IDLE=2'd0, S_DRIVE=2'd1, S_GAP=2'd2
//    - IDX_W=3, OUT_W=8
//  - Sub-module decoder_3to8_comb: pure combinational idx->y decode. It contains
//    the DEC_THERMO_EN switch and is instantiated once on the latched idx.
//  - The top level holds the FSM, counter, idx register and output registers.
// TESTING
//  1. Reset: hold rst_n=0 for 3 cycles -> y=00, busy=0, done=0, in_ready=1.
//  2. Defaults, in_idx=5 pulsed 1 cycle -> y=8'h20 for cycles 1..4 after accept.
//     done is high on cycle 4; y=0 on cycle 5; in_ready=1 on cycle 6.
//  3. in_valid held high, idx 0..7 cycled -> each code is accepted 6 cycles apart.
//     The y sequence is 01,02,..,80, and there is no accept while busy.
//  4. PULSE_LEN=1, GAP_LEN=0, idx=7 -> y=80 for 1 cycle with done coincident.
//     The next accept is possible 2 cycles after the first.
//  5. Mid-DRIVE reset (rst_n low for 1 cycle) -> y=00 asynchronously, no done,
//    and the next index is accepted normally.
//  6. DEC_THERMO_EN build, idx=3 -> y=8'h0F; idx=0 -> y=8'h01; idx=7 -> y=8'hFF.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants and state type for the sequenced 3-to-8 decoder.
package decoder_pkg;

   localparam int IDX_W = 3;
   localparam int OUT_W = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_DRIVE = S_DRIVE,
      ST_GAP   = S_GAP
   } state_t;

endpackage

// File: rtl/decoder_3to8_comb.sv
// Pure combinational index-to-word decode: one-hot by default,
// thermometer code when DEC_THERMO_EN is defined.
module decoder_3to8_comb
   import decoder_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [OUT_W-1:0] y
);

`ifdef DEC_THERMO_EN
   always_comb begin
      y = '0;
      for (int i = 0; i < OUT_W; i++) begin
         y[i] = (IDX_W'(i) <= idx);
      end
   end
`else
   always_comb begin
      y = '0;
      y[idx] = 1'b1;
   end
`endif

endmodule

// File: rtl/decoder_3to8_pulse.sv
// Sequenced 3-to-8 decoder: accepts an index, drives the decoded word for
// PULSE_LEN cycles, then forces zero for GAP_LEN cycles. Build option: DEC_THERMO_EN.
//
// state | meaning
// IDLE  | y=0, in_ready=1, waiting for an index
// DRIVE | y=decode(idx) for PULSE_LEN cycles, done on the last one
// GAP   | y=0 for GAP_LEN cycles before returning to IDLE
module decoder_3to8_pulse
   import decoder_pkg::*;
#(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1,
   parameter int CW        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   output logic             in_ready,
   output logic [OUT_W-1:0] y,
   output logic             busy,
   output logic             done
);

   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_LEN - 1);
   localparam logic [CW-1:0] GAP_LD   = (GAP_LEN == 0) ? '0 : CW'(GAP_LEN - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [OUT_W-1:0] y_q, y_d, dec_y;
   logic             done_q, done_d;

   // Decode the index being latched so y registers on the accept edge (1-cycle latency).
   decoder_3to8_comb u_dec (
      .idx (idx_d),
      .y   (dec_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         y_q     <= y_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               idx_d   = in_idx;
               cnt_d   = PULSE_LD;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (GAP_LEN == 0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d   = GAP_LD;
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      y_d    = (state_d == ST_DRIVE) ? dec_y : '0;
      done_d = (state_d == ST_DRIVE) && (cnt_d == '0);
   end

   assign in_ready = (state_q == ST_IDLE);
   assign busy     = (state_q != ST_IDLE);
   assign y        = y_q;
   assign done     = done_q;

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Randomized and directed bench for decoder_3to8_pulse against a cycle-count reference model.
module tb_decoder_3to8_pulse;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] in_idx;
   logic       ready_a, busy_a, done_a, ready_b, busy_b, done_b;
   logic [7:0] y_a, y_b;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int since_a = 0, since_b = 0;
   logic [2:0] midx_a = '0, midx_b = '0;

   always #5 clk = ~clk;

   decoder_3to8_pulse #(.PULSE_LEN(4), .GAP_LEN(1), .CW(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx),
      .in_ready(ready_a), .y(y_a), .busy(busy_a), .done(done_a));

   decoder_3to8_pulse #(.PULSE_LEN(1), .GAP_LEN(0), .CW(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx),
      .in_ready(ready_b), .y(y_b), .busy(busy_b), .done(done_b));

   always @(posedge clk) begin
      if (rst_n && in_valid && ready_a)
         assert (!$isunknown(in_idx)) else $error("in_idx unknown at accept");
   end

   function automatic logic [7:0] ref_dec(input logic [2:0] idx);
      int n;
      n = int'(idx);
`ifdef DEC_THERMO_EN
      return 8'((16'd1 << (n + 1)) - 16'd1);
`else
      return 8'(16'd1 << n);
`endif
   endfunction

   // since: 0 = idle, 1..p = pulse cycle number, p+1..p+g = gap cycle number
   task automatic step(input int p, input int g, inout int since, inout logic [2:0] idx);
      if (since == 0) begin
         if (in_valid) begin
            since = 1;
            idx   = in_idx;
         end
      end else if (since < p + g) begin
         since = since + 1;
      end else begin
         since = 0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         since_a = 0;
         since_b = 0;
      end else begin
         cyc = cyc + 1;
         step(4, 1, since_a, midx_a);
         step(1, 0, since_b, midx_b);
      end
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic check_dut(input string nm, input int p, input int since, input logic [2:0] idx,
                            input logic [7:0] y, input logic done, input logic busy,
                            input logic ready);
      logic [7:0] ey;
      ey = (since >= 1 && since <= p) ? ref_dec(idx) : 8'h00;
      chk({nm, "_y"}, y, ey);
      chk({nm, "_done"}, {7'd0, done}, {7'd0, since == p});
      chk({nm, "_busy"}, {7'd0, busy}, {7'd0, since != 0});
      chk({nm, "_ready"}, {7'd0, ready}, {7'd0, since == 0});
   endtask

   task automatic tick();
      @(negedge clk);
      check_dut("a", 4, since_a, midx_a, y_a, done_a, busy_a, ready_a);
      check_dut("b", 1, since_b, midx_b, y_b, done_b, busy_b, ready_b);
   endtask

   initial begin
      int k, last, budget;
      rst_n = 1'b0; in_valid = 1'b0; in_idx = '0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_y", y_a, 8'h00);
         chk("rst_busy", {7'd0, busy_a}, 8'h00);
         chk("rst_done", {7'd0, done_a}, 8'h00);
         chk("rst_ready", {7'd0, ready_a}, 8'h01);
      end
      rst_n = 1'b1;
      tick();

      // single accept, idx 5
      in_valid = 1'b1; in_idx = 3'd5;
      tick();
      in_valid = 1'b0;
      chk("t2_first_y", y_a, ref_dec(3'd5));
      repeat (8) tick();

      // valid held, idx cycled 0..7; accepts must be exactly 6 apart on dut_a
      k = 0; last = -1; budget = 0;
      in_valid = 1'b1; in_idx = 3'd0;
      while (k < 8 && budget < 80) begin
         tick();
         budget++;
         if (since_a == 1) begin
            if (last >= 0) chk("t3_gap", 8'(cyc - last), 8'd6);
            last = cyc;
            k++;
            in_idx = 3'(k);
         end
      end
      chk("t3_count", 8'(k), 8'd8);
      in_valid = 1'b0;
      repeat (8) tick();

      // mid-DRIVE asynchronous reset
      in_valid = 1'b1; in_idx = 3'd2;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("t5_y_async", y_a, 8'h00);
      chk("t5_busy", {7'd0, busy_a}, 8'h00);
      chk("t5_done", {7'd0, done_a}, 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1; in_idx = 3'd6;
      tick();
      in_valid = 1'b0;
      chk("t5_next_y", y_a, ref_dec(3'd6));
      repeat (8) tick();

      // thermometer/one-hot boundary indices
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1;
         in_idx = (j == 0) ? 3'd3 : (j == 1) ? 3'd0 : 3'd7;
         tick();
         in_valid = 1'b0;
         repeat (7) tick();
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_idx = 3'($urandom_range(0, 7));
         tick();
      end
      in_valid = 1'b0;
      repeat (8) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
